// File: rtl/instruction_fetch_mem.sv
// Programmable instruction memory with a registered, handshaked fetch stage.
// Each fetched word is split into OPCode / Rs / Four_Zero_Bits; out-of-range fetches return a flagged NOP.
module instruction_fetch_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int OP_W   = 3,
  parameter int RS_W   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        PCinst,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [OP_W-1:0]          OPCode,
  output logic [RS_W-1:0]          Rs,
  output logic [DATA_W-OP_W-1:0]   Four_Zero_Bits,
  output logic                     addr_err,
  input  logic                     prog_en,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LO_W  = DATA_W - OP_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              fetch_in_range;
  logic              prog_in_range;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  prog_idx;
  logic [DATA_W-1:0] rd_word;
  logic              accept;

  logic              inst_valid_q, inst_valid_d;
  logic              addr_err_q, addr_err_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [RS_W-1:0]   rs_q, rs_d;
  logic [LO_W-1:0]   low_q, low_d;

  // When the array covers the whole address space every address is legal.
  generate
    if (DEPTH >= 2**ADDR_W) begin : g_full_range
      assign fetch_in_range = 1'b1;
      assign prog_in_range  = 1'b1;
    end else begin : g_partial_range
      assign fetch_in_range = (PCinst < ADDR_W'(DEPTH));
      assign prog_in_range  = (prog_addr < ADDR_W'(DEPTH));
    end
  endgenerate

  assign fetch_idx = PCinst[IDX_W-1:0];
  assign prog_idx  = prog_addr[IDX_W-1:0];

  // Write-first: a same-cycle write to the fetched address is forwarded.
  always_comb begin
    rd_word = mem[fetch_idx];
    if (prog_en && prog_in_range && (prog_addr == PCinst)) begin
      rd_word = prog_data;
    end
  end

  assign fetch_ready = !inst_valid_q || inst_ready;
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    inst_valid_d = inst_valid_q;
    addr_err_d   = addr_err_q;
    opcode_d     = opcode_q;
    rs_d         = rs_q;
    low_d        = low_q;
    if (accept) begin
      inst_valid_d = 1'b1;
      if (fetch_in_range) begin
        addr_err_d = 1'b0;
        opcode_d   = rd_word[DATA_W-1 -: OP_W];
        rs_d       = rd_word[DATA_W-OP_W-1 -: RS_W];
        low_d      = rd_word[LO_W-1:0];
      end else begin
        addr_err_d = 1'b1;
        opcode_d   = '0;
        rs_d       = '0;
        low_d      = '0;
      end
    end else if (inst_ready) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      opcode_q     <= '0;
      rs_q         <= '0;
      low_q        <= '0;
    end else begin
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      opcode_q     <= opcode_d;
      rs_q         <= rs_d;
      low_q        <= low_d;
    end
  end

  // Contents survive reset; writes are only blocked while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset && prog_en && prog_in_range) begin
      mem[prog_idx] <= prog_data;
    end
  end

  assign inst_valid     = inst_valid_q;
  assign addr_err       = addr_err_q;
  assign OPCode         = opcode_q;
  assign Rs             = rs_q;
  assign Four_Zero_Bits = low_q;

endmodule
